// File: rtl/running_light_ctrl_if.sv
// Step/control inputs and LED/position outputs of the running-light controller.
interface running_light_ctrl_if #(
  parameter int LED_NUM = 4,
  parameter int POS_W   = 4
);
  logic               step_in;
  logic               en;
  logic [1:0]         mode;
  logic [LED_NUM-1:0] led;
  logic [POS_W-1:0]   pos;
  logic               sweep_done;

  modport master (output step_in, en, mode, input led, pos, sweep_done);
  modport slave  (input step_in, en, mode, output led, pos, sweep_done);
endinterface

// File: rtl/running_light_ctrl.sv
// Single lit LED advanced by each level change of step_in; no backpressure.
// Latency: pos/sweep_done update 2 edges after step_in is first captured, led one edge later.
module running_light_ctrl #(
  parameter int   LED_NUM        = 4,
  parameter logic LED_ACTIVE_LOW = 1'b0,
  parameter int   POS_W          = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  running_light_ctrl_if.slave   bus
);

  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;

  localparam logic [POS_W-1:0]   ZERO    = '0;
  localparam logic [POS_W-1:0]   ONE     = POS_W'(1);
  localparam logic [POS_W-1:0]   LAST    = POS_W'(LED_NUM - 1);
  localparam logic [POS_W-1:0]   PRELAST = POS_W'(LED_NUM - 2);
  localparam logic [LED_NUM-1:0] LED_ONE = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_INV = {LED_NUM{LED_ACTIVE_LOW}};

  logic               s1_q, s2_q, s3_q;
  logic [POS_W-1:0]   pos_q, pos_d;
  dir_t               dir_q, dir_d;
  logic               sweep_q, sweep_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               step;

  assign step = s2_q ^ s3_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pos_q   <= ZERO;
      dir_q   <= LEFT;
      sweep_q <= 1'b0;
      led_q   <= LED_ONE ^ LED_INV;
    end else begin
      s1_q    <= bus.step_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      sweep_q <= sweep_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    sweep_d = 1'b0;
    if (step && bus.en) begin
      unique case (bus.mode)
        2'b00: begin
          dir_d = LEFT;
          if (pos_q == LAST) begin
            pos_d   = ZERO;
            sweep_d = 1'b1;
          end else begin
            pos_d = pos_q + ONE;
          end
        end
        2'b01: begin
          dir_d = RIGHT;
          if (pos_q == ZERO) begin
            pos_d   = LAST;
            sweep_d = 1'b1;
          end else begin
            pos_d = pos_q - ONE;
          end
        end
        2'b10: begin
          // Bounce happens on the step that would leave the range, so end LEDs light once.
          if (dir_q == LEFT) begin
            if (pos_q == LAST) begin
              dir_d = RIGHT;
              pos_d = PRELAST;
            end else begin
              pos_d = pos_q + ONE;
            end
          end else begin
            if (pos_q == ZERO) begin
              dir_d = LEFT;
              pos_d = ONE;
            end else begin
              pos_d = pos_q - ONE;
            end
          end
          sweep_d = (pos_d == ZERO);
        end
        2'b11: begin
        end
      endcase
    end
    led_d = bus.en ? ((LED_ONE << pos_q) ^ LED_INV) : LED_INV;
  end

  assign bus.pos        = pos_q;
  assign bus.led        = led_q;
  assign bus.sweep_done = sweep_q;

endmodule

// File: tb/tb_running_light_ctrl.sv
// Randomised and directed stimulus for running_light_ctrl; a monitor checks each position change against a queue.
module tb_running_light_ctrl;
  localparam int N = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  running_light_ctrl_if #(.LED_NUM(N), .POS_W(4)) bh ();
  running_light_ctrl_if #(.LED_NUM(N), .POS_W(4)) bl ();

  running_light_ctrl #(.LED_NUM(N), .LED_ACTIVE_LOW(1'b0), .POS_W(4)) dut_h (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bh));
  running_light_ctrl #(.LED_NUM(N), .LED_ACTIVE_LOW(1'b1), .POS_W(4)) dut_l (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bl));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {int pos; int sw; int t;} exp_t;
  exp_t q[$];

  int   total = 0;
  int   bad   = 0;
  int   m_pos = 0;
  int   m_dir = 0;  // 0 = increasing index, 1 = decreasing
  logic lvl   = 1'b0;
  logic done  = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int led_exp(int pos, bit en, bit al);
    int v;
    v = en ? (1 << pos) : 0;
    if (al) v = v ^ ((1 << N) - 1);
    return v;
  endfunction

  // Reference: ping-pong is a walk around a cycle of 2(N-1) phases.
  function automatic void model_step(int mode, output int sw);
    int ph, per;
    sw = 0;
    per = 2 * (N - 1);
    case (mode)
      0: begin sw = (m_pos == N - 1); m_pos = (m_pos + 1) % N; m_dir = 0; end
      1: begin sw = (m_pos == 0); m_pos = (m_pos + N - 1) % N; m_dir = 1; end
      2: begin
        ph = (m_dir == 0) ? m_pos : (per - m_pos) % per;
        ph = (ph + 1) % per;
        m_pos = (ph < N) ? ph : per - ph;
        m_dir = (ph >= N - 1) ? 1 : 0;
        sw = (m_pos == 0);
      end
      default: ;
    endcase
  endfunction

  task automatic set_in(bit en, int mode);
    bh.en = en;  bl.en = en;
    bh.mode = 2'(mode); bl.mode = 2'(mode);
  endtask

  task automatic toggle(int mode, bit en);
    int sw;
    exp_t e;
    @(negedge sys_clk);
    set_in(en, mode);
    lvl = ~lvl;
    bh.step_in = lvl; bl.step_in = lvl;
    if (en && mode != 3) begin
      model_step(mode, sw);
      e.pos = m_pos; e.sw = sw; e.t = cyc;
      q.push_back(e);
    end
    repeat (10) @(negedge sys_clk);
    chk("hold_pos", bh.pos, m_pos);
    chk("hold_led_h", bh.led, led_exp(m_pos, en, 0));
    chk("hold_led_l", bl.led, led_exp(m_pos, en, 1));
  endtask

  task automatic async_reset();
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_led_h", bh.led, 1);
    chk("async_led_l", bl.led, 4'he);
    chk("async_pos", bh.pos, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      lvl = ~lvl; bh.step_in = lvl; bl.step_in = lvl;
      @(negedge sys_clk);
      chk("rst_led_h", bh.led, 1);
      chk("rst_led_l", bl.led, 4'he);
      chk("rst_pos", bh.pos, 0);
      chk("rst_sweep", bh.sweep_done, 0);
    end
    lvl = 1'b0; bh.step_in = 1'b0; bl.step_in = 1'b0;
    m_pos = 0; m_dir = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("post_rst_pos", bh.pos, 0);
    chk("post_rst_led_h", bh.led, led_exp(0, bh.en, 0));
  endtask

  // Monitor: any position change or sweep pulse must match the next queued expectation.
  initial begin
    int prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge sys_clk);
      if (done) break;
      if (!sys_rst_n) begin
        prev = int'(bh.pos);
        continue;
      end
      if (int'(bh.pos) != prev || bh.sweep_done || bl.pos != bh.pos) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_step: pos %0d (was %0d) sweep %0d, nothing queued", bh.pos, prev, bh.sweep_done);
        end else begin
          e = q.pop_front();
          chk("step_pos_h", bh.pos, e.pos);
          chk("step_pos_l", bl.pos, e.pos);
          chk("step_sweep_h", bh.sweep_done, e.sw);
          chk("step_sweep_l", bl.sweep_done, e.sw);
          chk("step_latency", cyc - e.t, 3);
          @(negedge sys_clk);
          chk("step_led_h", bh.led, led_exp(e.pos, 1, 0));
          chk("step_led_l", bl.led, led_exp(e.pos, 1, 1));
          chk("sweep_one_cycle", bh.sweep_done, 0);
        end
        prev = int'(bh.pos);
      end
    end
  end

  initial begin
    bh.step_in = 1'b0; bl.step_in = 1'b0;
    set_in(1'b1, 0);
    // Power-up reset with the step input toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      lvl = ~lvl; bh.step_in = lvl; bl.step_in = lvl;
      @(negedge sys_clk);
      chk("rst0_led_h", bh.led, 1);
      chk("rst0_led_l", bl.led, 4'he);
      chk("rst0_pos", bh.pos, 0);
      chk("rst0_sweep", bh.sweep_done, 0);
    end
    lvl = 1'b0; bh.step_in = 1'b0; bl.step_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("rel_pos", bh.pos, 0);

    for (int i = 0; i < 5; i++) toggle(0, 1'b1);   // 1,2,3,0,1
    toggle(1, 1'b1);                              // back to 0
    for (int i = 0; i < 4; i++) toggle(1, 1'b1);   // 3,2,1,0
    async_reset();
    for (int i = 0; i < 8; i++) toggle(2, 1'b1);   // 1,2,3,2,1,0,1,2
    chk("pp_end_pos", bh.pos, 2);
    for (int i = 0; i < 3; i++) toggle(3, 1'b1);
    for (int i = 0; i < 2; i++) toggle(2, 1'b0);
    chk("en0_led_h", bh.led, 0);
    @(negedge sys_clk);
    set_in(1'b1, 3);
    @(negedge sys_clk);
    chk("en1_led_l", bl.led, 4'b1011);
    chk("en1_led_h", bh.led, 4'b0100);
    async_reset();

    for (int i = 0; i < 80; i++)
      toggle(int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));

    repeat (5) @(negedge sys_clk);
    done = 1'b1;
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
